pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Stall/flush sequencer for the five-stage MIPS pipeline, working alongside the EX-stage operand forwarding logic. It handles three cases forwarding cannot cover: load-use hazards, taken branches resolved in MEM, and multi-cycle mult/div occupancy of EX. It drives the PC and pipeline-register write/flush controls and keeps a saturating stall-cycle counter.

## Interface
- MULDIV_LATENCY, default 4: total cycles a mult/div instruction occupies EX; legal range 1..16.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- ID_EX_MemRead  input  1  instruction in ID/EX is a load.
- ID_EX_RegisterRt  input  5  load destination register.
- IF_ID_RegisterRs  input  5  source register rs of instruction in ID.
- IF_ID_RegisterRt  input  5  source register rt of instruction in ID.
- EX_MulDiv  input  1  valid mult/div instruction in ID/EX (in EX this cycle).
- MEM_BranchTaken  input  1  branch in EX/MEM resolved taken.
- PC_Write  output  1  PC load enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- ID_EX_Write  output  1  ID/EX register load enable.
- IF_ID_Flush  output  1  IF/ID loads a bubble.
- ID_EX_Flush  output  1  ID/EX loads a bubble.
- EX_MEM_Flush  output  1  EX/MEM loads a bubble.
- MulDiv_Busy  output  1  FSM in MD_BUSY.
- MulDiv_Done  output  1  mult/div result valid in EX this cycle; advances to EX/MEM.
- Stall_Count  output  16  saturating count of cycles with PC_Write=0.

## Operation
- Load-use hazard LU = ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt).
- FSM states: RUN, MD_BUSY. 4-bit down-counter cnt.
- Control outputs are combinational from state, cnt and inputs; defaults: all Write=1, all Flush=0, Done=0.
- RUN, priority 1, MEM_BranchTaken=1: IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PC_Write=1; stays RUN; EX_MulDiv and LU ignored.
- RUN, priority 2, EX_MulDiv=1:
  - MULDIV_LATENCY=1: MulDiv_Done=1, no stall, stays RUN.
  - Otherwise: PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1; next state MD_BUSY, cnt<=MULDIV_LATENCY-2.
- RUN, priority 3, LU=1: PC_Write=IF_ID_Write=0, ID_EX_Flush=1 (one bubble); stays RUN.
- MD_BUSY, cnt!=0: same stall outputs as MD entry; cnt decrements.
- MD_BUSY, cnt==0: no stall, MulDiv_Done=1; next state RUN.
- MD_BUSY: MEM_BranchTaken, LU and EX_MulDiv are ignored. MEM holds only bubbles during MD_BUSY.
- MulDiv_Busy=1 exactly when state==MD_BUSY.
- Stall_Count increments on each rising edge where PC_Write=0 and reset=0. It holds at 16'hFFFF.

## Timing
- Reset (sync): state<=RUN, cnt<=0, Stall_Count<=0.
- While reset=1, outputs are forced to defaults: all Write=1, all Flush=0, MulDiv_Busy=0, MulDiv_Done=0.
- Reset asserted in MD_BUSY aborts the operation; next cycle RUN with no Done pulse.
- Load-use: exactly 1 stall cycle. Branch: 1 flush cycle, 0 stall.
- Mult/div entering EX at cycle T:
  - Stall asserted T..T+L-2 (L-1 cycles).
  - MulDiv_Done at T+L-1.
  - Next instruction enters EX at T+L.
- MulDiv_Busy high T+1..T+L-1.
- A branch in MEM at cycle T together with EX_MulDiv: the flush wins, no MD_BUSY entry, and the mult/div is squashed.
- LU coincident with EX_MulDiv in RUN: the mult/div stall covers it. After release, LU is re-evaluated against the new ID/EX contents.
- Stall_Count reflects the stall of cycle N from cycle N+1.

## Test plan
- Load-use: lw $2 in ID/EX (MemRead=1, Rt=2), IF_ID Rs=2 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_Count 0->1. Repeat with Rt=0 -> no stall.
- Branch: MEM_BranchTaken=1 with EX_MulDiv=1 and LU true -> IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush all 1, PC_Write=1, state stays RUN, no Done.
- Mult/div, L=4: EX_MulDiv at T ->
  - stall at T, T+1, T+2;
  - MulDiv_Busy at T+1..T+3;
  - MulDiv_Done only at T+3;
  - Stall_Count=3.
- L=1 build: EX_MulDiv=1 -> MulDiv_Done=1 same cycle, no stall, MulDiv_Busy never 1.
- Reset at T+1 of an L=4 mult/div -> outputs at defaults in the reset cycle; RUN afterwards; Stall_Count=0; no Done pulse.
- Saturation: hold LU true for 70000 cycles -> Stall_Count stops at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline.
// Covers load-use, taken branches in MEM and multi-cycle mult/div in EX.
module pipeline_hazard_controller #(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        EX_MulDiv,
  input  logic        MEM_BranchTaken,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        MulDiv_Busy,
  output logic        MulDiv_Done,
  output logic [15:0] Stall_Count
);

  typedef enum logic [0:0] {
    RUN,
    MD_BUSY
  } state_t;

  // Busy cycles remaining after the entry cycle and before the Done cycle.
  localparam logic [3:0] CNT_INIT =
    (MULDIV_LATENCY >= 2) ? 4'(MULDIV_LATENCY - 2) : 4'd0;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       lu;

  assign lu = ID_EX_MemRead
           && (ID_EX_RegisterRt != 5'd0)
           && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
            || (ID_EX_RegisterRt == IF_ID_RegisterRt));

  // Next state and control outputs; reset forces the defaults.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MulDiv_Busy  = 1'b0;
    MulDiv_Done  = 1'b0;
    state_n      = state;
    cnt_n        = cnt;
    if (!reset) begin
      case (state)
        RUN: begin
          if (MEM_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
          end else if (EX_MulDiv) begin
            if (MULDIV_LATENCY == 1) begin
              MulDiv_Done = 1'b1;
            end else begin
              PC_Write     = 1'b0;
              IF_ID_Write  = 1'b0;
              ID_EX_Write  = 1'b0;
              EX_MEM_Flush = 1'b1;
              state_n      = MD_BUSY;
              cnt_n        = CNT_INIT;
            end
          end else if (lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          MulDiv_Busy = 1'b1;
          if (cnt != 4'd0) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            cnt_n        = cnt - 4'd1;
          end else begin
            MulDiv_Done = 1'b1;
            state_n     = RUN;
          end
        end
      endcase
    end
  end

  // State and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      Stall_Count <= 16'd0;
    end else if (!PC_Write && (Stall_Count != 16'hFFFF)) begin
      Stall_Count <= Stall_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Main DUT at latency 4, second instance at latency 1.
module tb_pipeline_hazard_controller;

  localparam logic [7:0] DEF = 8'b1110_0000;
  localparam logic [7:0] LUS = 8'b0010_1000;
  localparam logic [7:0] BRF = 8'b1111_1100;
  localparam logic [7:0] MDE = 8'b0000_0100;
  localparam logic [7:0] MDB = 8'b0000_0110;
  localparam logic [7:0] MDD = 8'b1110_0011;
  localparam logic [7:0] MD1 = 8'b1110_0001;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md;
    logic       br;
    logic       md1;
    logic [7:0] c;
    logic [7:0] c1;
  } row_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_EX_MemRead = 1'b0;
  logic [4:0]  ID_EX_RegisterRt = 5'd0;
  logic [4:0]  IF_ID_RegisterRs = 5'd0;
  logic [4:0]  IF_ID_RegisterRt = 5'd0;
  logic        EX_MulDiv = 1'b0;
  logic        MEM_BranchTaken = 1'b0;
  logic        md1 = 1'b0;
  logic        z1 = 1'b0;
  logic [4:0]  z5 = 5'd0;

  logic        PC_Write, IF_ID_Write, ID_EX_Write;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
  logic        MulDiv_Busy, MulDiv_Done;
  logic [15:0] Stall_Count;
  logic        p1, iw1, ew1, if1, idf1, exf1, b1, d1;
  logic [15:0] sc1;
  logic [7:0]  ctl, ctl1;

  exp_t        sb[$];
  logic [7:0]  sb1[$];
  logic [15:0] exp_sc = 16'd0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign ctl  = {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush,
                 ID_EX_Flush, EX_MEM_Flush, MulDiv_Busy, MulDiv_Done};
  assign ctl1 = {p1, iw1, ew1, if1, idf1, exf1, b1, d1};

  pipeline_hazard_controller #(.MULDIV_LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .EX_MulDiv(EX_MulDiv),
    .MEM_BranchTaken(MEM_BranchTaken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Write(ID_EX_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .MulDiv_Busy(MulDiv_Busy), .MulDiv_Done(MulDiv_Done),
    .Stall_Count(Stall_Count)
  );

  pipeline_hazard_controller #(.MULDIV_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(z1),
    .ID_EX_RegisterRt(z5),
    .IF_ID_RegisterRs(z5),
    .IF_ID_RegisterRt(z5),
    .EX_MulDiv(md1),
    .MEM_BranchTaken(z1),
    .PC_Write(p1), .IF_ID_Write(iw1),
    .ID_EX_Write(ew1), .IF_ID_Flush(if1),
    .ID_EX_Flush(idf1), .EX_MEM_Flush(exf1),
    .MulDiv_Busy(b1), .MulDiv_Done(d1),
    .Stall_Count(sc1)
  );

  function automatic row_t r(
    input logic rst, input logic mr, input logic [4:0] ert,
    input logic [4:0] rs, input logic [4:0] rt, input logic md,
    input logic br, input logic m1, input logic [7:0] c,
    input logic [7:0] c1
  );
    r = '{rst, mr, ert, rs, rt, md, br, m1, c, c1};
  endfunction

  task automatic drive(input row_t x);
    reset            = x.rst;
    ID_EX_MemRead    = x.mr;
    ID_EX_RegisterRt = x.ert;
    IF_ID_RegisterRs = x.rs;
    IF_ID_RegisterRt = x.rt;
    EX_MulDiv        = x.md;
    MEM_BranchTaken  = x.br;
    md1              = x.md1;
    sb.push_back('{x.c, exp_sc});
    sb1.push_back(x.c1);
    if (x.rst) exp_sc = 16'd0;
    else if (!x.c[7] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    @(posedge clk);
    #1;
    exp_sc = 16'd0;
    rows = '{
      r(1, 0, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(1, 1, 2, 2, 0, 1, 1, 1, DEF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e || ctl1 !== e1) begin
        failures++;
        $display("FAIL reset[%0d] ctl=%b ctl1=%b sc=%0d expected ctl=%b ctl1=%b sc=%0d",
                 i, ctl, ctl1, Stall_Count, e.ctl, e1, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 1, 2, 2, 5, 0, 0, 0, LUS, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(0, 1, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(0, 1, 7, 3, 7, 0, 0, 0, LUS, DEF),
      r(0, 0, 3, 3, 3, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL load_use[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 1, 2, 2, 0, 1, 1, 0, BRF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL branch[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_muldiv();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 1, 4, 4, 0, 1, 0, 0, MDE, DEF),
      r(0, 1, 4, 4, 0, 1, 0, 0, MDB, DEF),
      r(0, 1, 4, 4, 0, 1, 1, 0, MDB, DEF),
      r(0, 1, 4, 4, 0, 1, 0, 0, MDD, DEF),
      r(0, 1, 4, 4, 0, 0, 0, 0, LUS, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL muldiv[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 0, 0, 0, 0, 1, 0, 0, MDE, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDB, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDB, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDD, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDE, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDB, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDB, DEF),
      r(0, 0, 0, 0, 0, 1, 0, 0, MDD, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_latency_one();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 0, 0, 0, 0, 0, 0, 1, DEF, MD1),
      r(0, 0, 0, 0, 0, 0, 0, 1, DEF, MD1),
      r(0, 0, 0, 0, 0, 0, 0, 1, DEF, MD1),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e || ctl1 !== e1) begin
        failures++;
        $display("FAIL latency_one[%0d] ctl1=%b ctl=%b expected ctl1=%b ctl=%b",
                 i, ctl1, ctl, e1, e.ctl);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (sc1 !== 16'd0) begin
      failures++;
      $display("FAIL latency_one_count sc1=%0d expected 0", sc1);
    end
  endtask

  task automatic test_reset_abort();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    rows = '{
      r(0, 0, 0, 0, 0, 1, 0, 0, MDE, DEF),
      r(1, 0, 0, 0, 0, 1, 0, 0, DEF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL reset_abort[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    exp_t e;
    logic [7:0] e1;
    reset            = 1'b0;
    ID_EX_MemRead    = 1'b1;
    ID_EX_RegisterRt = 5'd9;
    IF_ID_RegisterRs = 5'd9;
    IF_ID_RegisterRt = 5'd0;
    EX_MulDiv        = 1'b0;
    MEM_BranchTaken  = 1'b0;
    md1              = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    exp_sc = 16'hFFFF;
    rows = '{
      r(0, 1, 9, 9, 0, 0, 0, 0, LUS, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF),
      r(0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF)
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      e  = sb.pop_front();
      e1 = sb1.pop_front();
      checks++;
      if ({ctl, Stall_Count} !== e) begin
        failures++;
        $display("FAIL saturation[%0d] ctl=%b sc=%0d expected ctl=%b sc=%0d",
                 i, ctl, Stall_Count, e.ctl, e.sc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_latency_one();
    test_reset_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
